fetch_unit: RTL and testbench

Instruction-fetch stage of the 5-stage pipeline. Owns the program counter, issues instruction-memory read requests, and presents the fetched word, PC+4 and a flush qualifier to the IF/ID latch directly downstream. Handles redirects from branches and jumps resolved later in the pipe, including a redirect that arrives while a memory read is still outstanding. Also handles hazard-unit stalls and halt.

---
 rtl/cpu_types_pkg.sv | 30 +++
 rtl/fetch_unit_if.sv | 31 +++
 rtl/fetch_pc_reg.sv | 48 ++++
 rtl/fetch_unit.sv | 99 +++++++++
 tb/tb_fetch_unit.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared types and constants for the fetch stage
// Purpose: word type, fetch FSM states, next-pc select codes, pc step and
//          an alignment helper used by the fetch unit and its pc register.
// Ports:   none (package)
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    PEND = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  // Next-pc source chosen by the FSM each cycle.
  typedef enum logic [1:0] {
    PC_HOLD  = 2'd0,
    PC_SEQ   = 2'd1,
    PC_REDIR = 2'd2,
    PC_PEND  = 2'd3
  } pc_sel_t;

  localparam word_t PC_STEP = 32'd4;

  // Instruction addresses are word aligned; the low two bits are dropped.
  function automatic word_t align_pc(word_t addr);
    return addr & ~word_t'(32'h3);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch stage bus: imem port, control inputs, IF/ID outputs
// Purpose: bundles the instruction-memory handshake, hazard/redirect/halt
//          controls and the IF/ID-facing outputs of the fetch unit.
// Modports: master = fetch unit side, slave = memory/pipeline side.
interface fetch_unit_if;

  logic                      ihit;
  cpu_types_pkg::word_t      imemload;
  logic                      imemREN;
  cpu_types_pkg::word_t      imemaddr;
  logic                      stall;
  logic                      redirect;
  cpu_types_pkg::word_t      redirect_pc;
  logic                      halt;
  cpu_types_pkg::word_t      instr;
  cpu_types_pkg::word_t      pcp4;
  logic                      fetch_valid;
  logic                      flush;
  logic                      halted;

  modport master (
    input  ihit, imemload, stall, redirect, redirect_pc, halt,
    output imemREN, imemaddr, instr, pcp4, fetch_valid, flush, halted
  );

  modport slave (
    output ihit, imemload, stall, redirect, redirect_pc, halt,
    input  imemREN, imemaddr, instr, pcp4, fetch_valid, flush, halted
  );

endinterface

// File: rtl/fetch_pc_reg.sv
// rtl/fetch_pc_reg.sv - program counter and pending-redirect registers
// Purpose: holds pc and pend_pc and applies the next-pc select from the FSM.
// Ports:   clk, rst_n (async active-low), pc_sel (next-pc source),
//          pend_load (capture redirect_pc into pend_pc), redirect_pc,
//          pc / pend_pc (current register values).
module fetch_pc_reg
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0000_0000
) (
  input  logic    clk,
  input  logic    rst_n,
  input  pc_sel_t pc_sel,
  input  logic    pend_load,
  input  word_t   redirect_pc,
  output word_t   pc,
  output word_t   pend_pc
);

  word_t pc_d, pc_q;
  word_t pend_pc_d, pend_pc_q;

  always_comb begin
    pc_d      = pc_q;
    pend_pc_d = pend_pc_q;
    case (pc_sel)
      PC_SEQ:   pc_d = pc_q + PC_STEP;   // wraps naturally at 2^32
      PC_REDIR: pc_d = align_pc(redirect_pc);
      PC_PEND:  pc_d = pend_pc_q;
      default:  pc_d = pc_q;
    endcase
    if (pend_load) pend_pc_d = align_pc(redirect_pc);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= align_pc(PC_INIT);
      pend_pc_q <= '0;
    end else begin
      pc_q      <= pc_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  assign pc      = pc_q;
  assign pend_pc = pend_pc_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with redirect, stall and halt
// Purpose: RUN/PEND/HALT FSM driving the pc register, imem read request and
//          IF/ID qualifiers (fetch_valid, flush, halted).
// Ports:   CLK, nRST (async active-low), fif (fetch_unit_if.master).
module fetch_unit
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0000_0000
) (
  input  logic          CLK,
  input  logic          nRST,
  fetch_unit_if.master  fif
);

  fetch_state_t state_d, state_q;
  pc_sel_t      pc_sel;
  logic         pend_load;
  logic         flush;
  word_t        pc;
  word_t        pend_pc;

  fetch_pc_reg #(.PC_INIT(PC_INIT)) u_pc_reg (
    .clk         (CLK),
    .rst_n       (nRST),
    .pc_sel      (pc_sel),
    .pend_load   (pend_load),
    .redirect_pc (fif.redirect_pc),
    .pc          (pc),
    .pend_pc     (pend_pc)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_q <= RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    pc_sel    = PC_HOLD;
    pend_load = 1'b0;
    flush     = 1'b0;
    case (state_q)
      RUN: begin
        flush = fif.redirect;
        if (fif.halt) begin
          state_d = HALT;
        end else if (fif.redirect) begin
          if (fif.ihit) begin
            pc_sel = PC_REDIR;
          end else begin
            // The outstanding read cannot be cancelled: park the target
            // and wait for the stale word to come back.
            pend_load = 1'b1;
            state_d   = PEND;
          end
        end else if (fif.ihit && !fif.stall) begin
          pc_sel = PC_SEQ;
        end
      end
      PEND: begin
        // Every word returned while pending is wrong-path.
        flush = 1'b1;
        if (fif.halt) begin
          state_d = HALT;
        end else if (fif.redirect) begin
          // The newest target always wins, even on the releasing hit.
          if (fif.ihit) begin
            pc_sel  = PC_REDIR;
            state_d = RUN;
          end else begin
            pend_load = 1'b1;
          end
        end else if (fif.ihit) begin
          pc_sel  = PC_PEND;
          state_d = RUN;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  assign fif.imemREN     = (state_q != HALT);
  assign fif.imemaddr    = pc;
  assign fif.pcp4        = pc + PC_STEP;
  assign fif.instr       = fif.imemload;
  assign fif.fetch_valid = fif.ihit && (state_q != HALT);
  assign fif.flush       = flush;
  assign fif.halted      = (state_q == HALT);

  // pend_pc is consumed inside the register block; keep it observable here.
  logic unused_pend;
  assign unused_pend = ^pend_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

  logic clk;
  logic nrst;
  int   n_cmp;
  int   n_err;

  fetch_unit_if fif ();

  fetch_unit #(.PC_INIT(32'h0000_0000)) dut (
    .CLK  (clk),
    .nRST (nrst),
    .fif  (fif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic ihit, input logic stall, input logic redirect,
                        input logic [31:0] rpc, input logic halt);
    fif.ihit        = ihit;
    fif.stall       = stall;
    fif.redirect    = redirect;
    fif.redirect_pc = rpc;
    fif.halt        = halt;
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    nrst  = 1'b0;
    fif.imemload = 32'h0000_0013;
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

    // Reset state
    expect_eq("rst_addr",   fif.imemaddr, 32'h0);
    expect_eq("rst_pcp4",   fif.pcp4, 32'h4);
    expect_eq("rst_ren",    {31'b0, fif.imemREN}, 32'h1);
    expect_eq("rst_flush",  {31'b0, fif.flush}, 32'h0);
    expect_eq("rst_halted", {31'b0, fif.halted}, 32'h0);
    expect_eq("rst_valid",  {31'b0, fif.fetch_valid}, 32'h0);
    #12;
    nrst = 1'b1;
    tick();

    // Sequential fetch, one word per hit
    set_in(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      fif.imemload = 32'hA000_0000 + i;
      #1;
      expect_eq("seq_addr",  fif.imemaddr, 32'(4 * i));
      expect_eq("seq_pcp4",  fif.pcp4, 32'(4 * i + 4));
      expect_eq("seq_flush", {31'b0, fif.flush}, 32'h0);
      expect_eq("seq_valid", {31'b0, fif.fetch_valid}, 32'h1);
      expect_eq("seq_instr", fif.instr, 32'hA000_0000 + i);
      tick();
    end
    expect_eq("seq_end", fif.imemaddr, 32'h10);

    // Stall at pc=8: restart from reset and advance two words
    nrst = 1'b0;
    #1;
    expect_eq("rerst_addr", fif.imemaddr, 32'h0);
    nrst = 1'b1;
    tick();
    tick();
    expect_eq("pre_stall", fif.imemaddr, 32'h8);
    set_in(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    expect_eq("stall1", fif.imemaddr, 32'h8);
    tick();
    expect_eq("stall2", fif.imemaddr, 32'h8);
    tick();
    set_in(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    expect_eq("stall_rel", fif.imemaddr, 32'h8);
    tick();
    expect_eq("post_stall", fif.imemaddr, 32'hC);
    tick();
    expect_eq("at_10", fif.imemaddr, 32'h10);

    // Redirect coinciding with a hit
    set_in(1'b1, 1'b0, 1'b1, 32'h40, 1'b0);
    expect_eq("redir_flush", {31'b0, fif.flush}, 32'h1);
    tick();
    set_in(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    expect_eq("redir_addr",  fif.imemaddr, 32'h40);
    expect_eq("redir_noflush", {31'b0, fif.flush}, 32'h0);

    // Move to pc=0x20 via a hit redirect
    set_in(1'b1, 1'b0, 1'b1, 32'h20, 1'b0);
    tick();
    // Redirect with read outstanding, then re-redirect, then hit
    set_in(1'b0, 1'b0, 1'b1, 32'h80, 1'b0);
    expect_eq("pend_c1_addr",  fif.imemaddr, 32'h20);
    expect_eq("pend_c1_flush", {31'b0, fif.flush}, 32'h1);
    expect_eq("pend_c1_valid", {31'b0, fif.fetch_valid}, 32'h0);
    tick();
    set_in(1'b0, 1'b0, 1'b1, 32'h90, 1'b0);
    expect_eq("pend_c2_addr",  fif.imemaddr, 32'h20);
    expect_eq("pend_c2_flush", {31'b0, fif.flush}, 32'h1);
    expect_eq("pend_c2_ren",   {31'b0, fif.imemREN}, 32'h1);
    tick();
    set_in(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    expect_eq("pend_c3_addr",  fif.imemaddr, 32'h20);
    expect_eq("pend_c3_flush", {31'b0, fif.flush}, 32'h1);
    tick();
    set_in(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    expect_eq("pend_target", fif.imemaddr, 32'h90);
    expect_eq("pend_done_flush", {31'b0, fif.flush}, 32'h0);

    // Wrap at top of address space; low redirect bits are ignored
    set_in(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
    tick();
    set_in(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    expect_eq("wrap_addr", fif.imemaddr, 32'hFFFF_FFFC);
    expect_eq("wrap_pcp4", fif.pcp4, 32'h0);
    tick();
    expect_eq("wrap_next", fif.imemaddr, 32'h0);
    tick();
    expect_eq("pre_halt", fif.imemaddr, 32'h4);

    // Halt beats a simultaneous redirect
    set_in(1'b1, 1'b0, 1'b1, 32'h100, 1'b1);
    tick();
    set_in(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      expect_eq("halt_halted", {31'b0, fif.halted}, 32'h1);
      expect_eq("halt_ren",    {31'b0, fif.imemREN}, 32'h0);
      expect_eq("halt_addr",   fif.imemaddr, 32'h4);
      expect_eq("halt_valid",  {31'b0, fif.fetch_valid}, 32'h0);
      expect_eq("halt_flush",  {31'b0, fif.flush}, 32'h0);
      tick();
    end

    // Reset pulse leaves halt
    #2;
    nrst = 1'b0;
    #1;
    expect_eq("unhalt_addr",   fif.imemaddr, 32'h0);
    expect_eq("unhalt_halted", {31'b0, fif.halted}, 32'h0);
    expect_eq("unhalt_ren",    {31'b0, fif.imemREN}, 32'h1);
    nrst = 1'b1;
    tick();
    expect_eq("after_rst_addr", fif.imemaddr, 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
